// File: rtl/led_frame_sequencer.sv
// -----------------------------------------------------------------------------
// led_frame_sequencer
//
// Walks the colour pipeline through every pixel of one LED frame. Each pixel
// index is driven on ledindex and held for HOLD_CYCLES clocks so the pipeline's
// phase rotation settles. The pipeline's red/green/blue is then captured and
// offered to the WS2811 serialiser. After the last pixel, the block idles for
// LATCH_CYCLES clocks (the WS2811 latch gap) before it pulses frame_done.
//
// Handshake: pix_valid is raised together with stable pix_data/pix_sof/pix_eof.
// All four are held until a clock edge with pix_valid && pix_ready, which is
// the transfer. pix_valid drops on that same edge. pix_ready is ignored while
// pix_valid is low.
//
// Optional build macro: LEDSEQ_REVERSE_EN
//   Adds the input 'reverse', which is sampled when a frame starts. When it
//   is high, the frame is sent in descending order NUM_LEDS-1..0.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous active-high reset, aborts any frame in flight
//   enable        frame request, looked at only while idle
//   reverse       (LEDSEQ_REVERSE_EN only) descending pixel order for the frame
//   led_red/green/blue  colour pipeline outputs for the current ledindex
//   ledindex      pixel index driven to the colour pipeline
//   pix_valid     pixel offer to the serialiser
//   pix_ready     serialiser accepts the offered pixel
//   pix_data      {red,green,blue} of the offered pixel
//   pix_sof       offered pixel is the first of the frame
//   pix_eof       offered pixel is the last of the frame
//   frame_active  high from the frame start through the end of the latch gap
//   frame_done    one-cycle pulse in the first idle cycle after the latch gap
// -----------------------------------------------------------------------------
module led_frame_sequencer #(
   parameter int NUM_LEDS     = 50,
   parameter int HOLD_CYCLES  = 16,
   parameter int LATCH_CYCLES = 2500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
`ifdef LEDSEQ_REVERSE_EN
   input  logic        reverse,
`endif
   input  logic [7:0]  led_red,
   input  logic [7:0]  led_green,
   input  logic [7:0]  led_blue,
   output logic [7:0]  ledindex,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [23:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eof,
   output logic        frame_active,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_OFFER = 2'd2,
      S_LATCH = 2'd3
   } state_e;

   localparam logic [7:0]  LAST_IDX   = 8'(NUM_LEDS - 1);
   localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
   localparam logic [15:0] LATCH_LAST = 16'(LATCH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  ledindex_q, ledindex_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic [15:0] latch_cnt_q, latch_cnt_d;
   logic        pix_valid_q, pix_valid_d;
   logic [23:0] pix_data_q, pix_data_d;
   logic        pix_sof_q, pix_sof_d;
   logic        pix_eof_q, pix_eof_d;
   logic        frame_done_q, frame_done_d;
   logic        dir_rev_q, dir_rev_d;   // direction frozen for the whole frame

   logic        rev_in;
   logic        xfer;
   logic [7:0]  first_idx;
   logic [7:0]  last_idx;
   logic [7:0]  next_idx;

`ifdef LEDSEQ_REVERSE_EN
   assign rev_in = reverse;
`else
   assign rev_in = 1'b0;
`endif

   assign xfer      = pix_valid_q && pix_ready;
   assign first_idx = dir_rev_q ? LAST_IDX : 8'd0;
   assign last_idx  = dir_rev_q ? 8'd0 : LAST_IDX;
   assign next_idx  = dir_rev_q ? (ledindex_q - 8'd1) : (ledindex_q + 8'd1);

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ledindex_q   <= 8'd0;
         hold_cnt_q   <= 8'd0;
         latch_cnt_q  <= 16'd0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= 24'd0;
         pix_sof_q    <= 1'b0;
         pix_eof_q    <= 1'b0;
         frame_done_q <= 1'b0;
         dir_rev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ledindex_q   <= ledindex_d;
         hold_cnt_q   <= hold_cnt_d;
         latch_cnt_q  <= latch_cnt_d;
         pix_valid_q  <= pix_valid_d;
         pix_data_q   <= pix_data_d;
         pix_sof_q    <= pix_sof_d;
         pix_eof_q    <= pix_eof_d;
         frame_done_q <= frame_done_d;
         dir_rev_q    <= dir_rev_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable)                    state_d = S_ADDR;
         S_ADDR:  if (hold_cnt_q == HOLD_LAST)   state_d = S_OFFER;
         S_OFFER: if (xfer)                      state_d = pix_eof_q ? S_LATCH : S_ADDR;
         S_LATCH: if (latch_cnt_q == LATCH_LAST) state_d = S_IDLE;
         default:                                state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------- datapath / outputs
   always_comb begin
      ledindex_d   = ledindex_q;
      hold_cnt_d   = hold_cnt_q;
      latch_cnt_d  = latch_cnt_q;
      pix_valid_d  = pix_valid_q;
      pix_data_d   = pix_data_q;
      pix_sof_d    = pix_sof_q;
      pix_eof_d    = pix_eof_q;
      frame_done_d = 1'b0;
      dir_rev_d    = dir_rev_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               dir_rev_d  = rev_in;
               ledindex_d = rev_in ? LAST_IDX : 8'd0;
               hold_cnt_d = 8'd0;
            end
         end
         S_ADDR: begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            // Pipeline has settled: capture on the last hold cycle.
            if (hold_cnt_q == HOLD_LAST) begin
               pix_data_d  = {led_red, led_green, led_blue};
               pix_sof_d   = (ledindex_q == first_idx);
               pix_eof_d   = (ledindex_q == last_idx);
               pix_valid_d = 1'b1;
            end
         end
         S_OFFER: begin
            if (xfer) begin
               pix_valid_d = 1'b0;
               if (pix_eof_q) begin
                  latch_cnt_d = 16'd0;
               end else begin
                  // Only advance when another pixel follows, so ledindex
                  // stays at the last index through LATCH and IDLE.
                  ledindex_d = next_idx;
                  hold_cnt_d = 8'd0;
               end
            end
         end
         S_LATCH: begin
            latch_cnt_d = latch_cnt_q + 16'd1;
            if (latch_cnt_q == LATCH_LAST) frame_done_d = 1'b1;
         end
         default: begin
            pix_valid_d = 1'b0;
         end
      endcase
   end

   assign ledindex     = ledindex_q;
   assign pix_valid    = pix_valid_q;
   assign pix_data     = pix_data_q;
   assign pix_sof      = pix_sof_q;
   assign pix_eof      = pix_eof_q;
   assign frame_done   = frame_done_q;
   assign frame_active = (state_q != S_IDLE);

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Sequences the per-pixel LED colour pipeline across one frame.
- Steps ledindex through 0..NUM_LEDS-1 and holds each index long enough for the colour pipeline's phase rotation to settle.
- Captures the resulting red/green/blue and hands each pixel to the WS2811 serialiser over a valid/ready handshake.
- Enforces the WS2811 latch gap between frames and flags frame start and end.

Parameters:
- NUM_LEDS, 50, pixels per frame; legal range 1..256.
- HOLD_CYCLES, 16, clocks each ledindex is held before sampling; two full 8-phase colour rotations; legal range 2..255.
- LATCH_CYCLES, 2500, idle clocks after the last pixel (50 us at 50 MHz); legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  frame request; sampled only in IDLE.
- led_red  in  8  colour pipeline red output.
- led_green  in  8  colour pipeline green output.
- led_blue  in  8  colour pipeline blue output.
- ledindex  out  8  pixel index driven to the colour pipeline.
- pix_valid  out  1  pix_data/pix_sof/pix_eof valid to serialiser.
- pix_ready  in  1  serialiser accepts the pixel.
- pix_data  out  24  {red,green,blue} captured pixel.
- pix_sof  out  1  qualifies the first pixel of a frame.
- pix_eof  out  1  qualifies the last pixel of a frame.
- frame_active  out  1  high in ADDR, OFFER and LATCH.
- frame_done  out  1  one-cycle pulse on LATCH->IDLE.

Behaviour:
- Reset values: state=IDLE, ledindex=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eof=0, frame_active=0, frame_done=0, all counters 0.
- Reset asserted mid-frame aborts immediately. No partial-frame flush. pix_valid drops on the next edge.
- State IDLE:
  - If enable=1: ledindex<=first index (0), hold_cnt<=0, go to ADDR.
  - Otherwise stay in IDLE.
- State ADDR:
  - hold_cnt increments each cycle; ledindex is stable.
  - When hold_cnt==HOLD_CYCLES-1: on that edge, pix_data<={led_red,led_green,led_blue}, pix_sof<=(index is first), pix_eof<=(index is last), pix_valid<=1, go to OFFER.
- State OFFER:
  - pix_valid=1. pix_data, pix_sof and pix_eof are held stable until accepted.
  - Transfer occurs on a cycle with pix_valid&&pix_ready.
  - On transfer, pix_valid<=0 (same edge). Then:
    - If pix_eof: go to LATCH, latch_cnt<=0.
    - Else: ledindex<=next index, hold_cnt<=0, go to ADDR.
  - pix_ready while pix_valid=0 is ignored.
- State LATCH:
  - latch_cnt increments.
  - When latch_cnt==LATCH_CYCLES-1: go to IDLE; frame_done=1 for exactly that next cycle.
- enable is not re-sampled mid-frame. Deasserting it completes the current frame.
- enable held high runs frames back to back, separated only by LATCH plus one IDLE cycle.
- Latency:
  - enable high in IDLE to first pix_valid = HOLD_CYCLES+1 clocks.
  - Minimum pixel period = HOLD_CYCLES+1 clocks with pix_ready tied high.
- NUM_LEDS=1: the single pixel has pix_sof=pix_eof=1.
- Counter widths: hold_cnt 8 bits, latch_cnt 16 bits. No wrap-around occurs within legal parameter ranges.
- ledindex remains at the last index during LATCH and IDLE.

Optional Feature:
- Macro: LEDSEQ_REVERSE_EN.
- When defined:
  - Adds input port reverse (1 bit), sampled only on the IDLE->ADDR transition and held for the whole frame.
  - reverse=1: first index is NUM_LEDS-1 and next index is ledindex-1. pix_sof marks NUM_LEDS-1, pix_eof marks 0.
  - reverse=0: normal ascending order.
- When undefined: the port is absent and order is always ascending 0..NUM_LEDS-1.

Test Plan:
- Reset then enable=1 for 1 cycle, NUM_LEDS=4, HOLD_CYCLES=16, pix_ready=1 -> pix_valid first high 17 clocks after enable; 4 pixels with ledindex 0,1,2,3; sof on pixel 0 only, eof on pixel 3 only; frame_done pulse 2500 clocks after the last transfer.
- Pipeline model returns rgb = {idx,~idx,idx^8'h55}; pix_ready held low 30 cycles at pixel 2 -> pix_valid stays high, pix_data=24'h02FD57 stable throughout; ledindex stays 2; transfer on first ready cycle.
- enable held high, NUM_LEDS=2, LATCH_CYCLES=10 -> back-to-back frames; ledindex returns to 0 one cycle after frame_done; frame_active low only during the single IDLE cycle.
- enable dropped during pixel 1 of 4 -> all 4 pixels still emitted, then IDLE; no second frame.
- Reset asserted in OFFER at pixel 2 -> next cycle pix_valid=0, ledindex=0, frame_active=0; no frame_done pulse.
- LEDSEQ_REVERSE_EN defined, reverse=1, NUM_LEDS=4 -> ledindex sequence 3,2,1,0; sof with index 3, eof with index 0.
